// File: rtl/regfile_pkg.sv
// Shared defaults for the register file / scoreboard slice: parameter defaults,
// the PC register encoding and the read-source selector used by every read port.
package regfile_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_NREG     = 16;
  localparam int RF_NRP      = 2;
  localparam int RF_MAX_PEND = 4;
  localparam bit RF_BYPASS   = 1'b1;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_PC   = 2'd1,
    SRC_FWD  = 2'd2,
    SRC_REG  = 2'd3
  } rd_src_e;

  // The PC lives in the top architectural slot and is never stored.
  function automatic int pc_reg_of(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, read, issue and scoreboard-status signals of the register file.
// master drives writes/reads/issues; slave (the register file) returns data and status.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREG  = RF_NREG,
  parameter int NRP   = RF_NRP
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH-1:0]     pc_in;
  logic [NRP*AW-1:0]    raddr;
  logic [NRP*WIDTH-1:0] rdata;
  logic [NRP-1:0]       rd_hazard;
  logic                 issue_valid;
  logic [AW-1:0]        issue_addr;
  logic                 issue_ready;
  logic                 flush;
  logic [NREG-1:0]      busy;
  logic [CW-1:0]        pend_count;

  modport master (
    output we, waddr, wdata, pc_in, raddr, issue_valid, issue_addr, flush,
    input  rdata, rd_hazard, issue_ready, busy, pend_count
  );

  modport slave (
    input  we, waddr, wdata, pc_in, raddr, issue_valid, issue_addr, flush,
    output rdata, rd_hazard, issue_ready, busy, pend_count
  );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port: selects PC, forwarded write data or stored value,
// zero latency; flags a hazard when the source is pending and not forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int NREG   = RF_NREG,
  parameter int PC_REG = pc_reg_of(RF_NREG),
  parameter bit BYPASS = RF_BYPASS,
  localparam int AW    = $clog2(NREG)
) (
  input  logic [AW-1:0]    raddr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] regs [NREG],
  input  logic [NREG-1:0]  busy,
  output logic [WIDTH-1:0] rdata,
  output logic             hazard
);

  logic [(1<<AW)-1:0] valid_map;
  rd_src_e            src;

  for (genvar k = 0; k < (1 << AW); k++) begin : g_map
    assign valid_map[k] = (k < NREG);
  end

  always_comb begin
    src = SRC_REG;
    if (!valid_map[raddr]) begin
      src = SRC_ZERO;
    end else if (raddr == AW'(PC_REG)) begin
      src = SRC_PC;
    end else if (BYPASS && we && (waddr == raddr)) begin
      src = SRC_FWD;
    end

    rdata  = '0;
    hazard = 1'b0;
    unique case (src)
      SRC_PC:  rdata = pc_in;
      SRC_FWD: rdata = wdata;
      SRC_REG: begin
        rdata  = regs[raddr];
        hazard = busy[raddr];
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with pending-write scoreboard: reads are combinational, writes and
// busy updates land on the next rising edge; issue_ready drops at MAX_PEND or on flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int NREG     = RF_NREG,
  parameter int NRP      = RF_NRP,
  parameter int PC_REG   = pc_reg_of(NREG),
  parameter int MAX_PEND = RF_MAX_PEND,
  parameter bit BYPASS   = RF_BYPASS
) (
  input  logic               clk,
  input  logic               reset,
  regfile_scoreboard_if.slave bus
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [WIDTH-1:0]   regs_q [NREG];
  logic [WIDTH-1:0]   regs_d [NREG];
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_d;
  logic [CW-1:0]      pend_count_q;
  logic [CW-1:0]      pend_count_d;
  logic [(1<<AW)-1:0] valid_map;
  logic               wr_hit;
  logic               wr_en;
  logic               issue_ready;
  logic               issue_set;

  for (genvar k = 0; k < (1 << AW); k++) begin : g_map
    assign valid_map[k] = (k < NREG);
  end

  always_comb begin
    wr_hit      = bus.we && valid_map[bus.waddr];
    wr_en       = wr_hit && (bus.waddr != AW'(PC_REG));
    issue_ready = (pend_count_q < CW'(MAX_PEND)) && !bus.flush;
    issue_set   = bus.issue_valid && issue_ready && valid_map[bus.issue_addr]
                  && (bus.issue_addr != AW'(PC_REG));

    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.waddr] = bus.wdata;
    end

    // Order matters: write clears, then issue sets, then flush overrides both.
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[bus.waddr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end

    pend_count_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_count_d = pend_count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      pend_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      pend_count_q <= pend_count_d;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    regfile_read_port #(
      .WIDTH  (WIDTH),
      .NREG   (NREG),
      .PC_REG (PC_REG),
      .BYPASS (BYPASS)
    ) u_rd (
      .raddr  (bus.raddr[p*AW +: AW]),
      .we     (bus.we),
      .waddr  (bus.waddr),
      .wdata  (bus.wdata),
      .pc_in  (bus.pc_in),
      .regs   (regs_q),
      .busy   (busy_q),
      .rdata  (bus.rdata[p*WIDTH +: WIDTH]),
      .hazard (bus.rd_hazard[p])
    );
  end

  assign bus.issue_ready = issue_ready;
  assign bus.busy        = busy_q;
  assign bus.pend_count  = pend_count_q;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, 32, data width of every register and port.
REQ-002 Parameter NREG, 16, number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter NRP, 2, number of read ports.
REQ-004 Parameter PC_REG, NREG-1, index of the register sourced from pc_in and never stored.
REQ-005 Parameter MAX_PEND, 4, maximum outstanding pending writes; range 1..NREG-1.
REQ-006 Parameter BYPASS, 1, enables same-cycle write-to-read forwarding.
REQ-007 clk  in  1  single clock, all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 we, waddr, wdata  in  1/AW/WIDTH  writeback port.
REQ-010 pc_in  in  WIDTH  value returned for reads of PC_REG.
REQ-011 raddr  in  NRP*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-012 rdata  out  NRP*WIDTH  packed read data, combinational.
REQ-013 rd_hazard  out  NRP  port i source is pending and not forwarded.
REQ-014 issue_valid, issue_addr  in  1/AW  request to mark a destination pending.
REQ-015 issue_ready  out  1  issue may be accepted this cycle.
REQ-016 flush  in  1  synchronous clear of all pending marks.
REQ-017 busy  out  NREG  pending-write bit per register.
REQ-018 pend_count  out  clog2(NREG+1)  number of set busy bits.

Function
REQ-019 Write: at rising edge, if we=1 and waddr!=PC_REG, reg[waddr] SHALL take wdata; writes to PC_REG are discarded.
REQ-020 Read port i: raddr=PC_REG -> pc_in; else BYPASS=1, we=1, waddr=raddr -> wdata; else reg[raddr]; zero latency.
REQ-021 Addresses >= NREG SHALL read 0, never write, never issue.
REQ-022 Issue accepted iff issue_valid=1 and issue_ready=1; issue_addr=PC_REG accepted but sets nothing.
REQ-023 issue_ready SHALL equal (pend_count < MAX_PEND) and flush=0, from registered state only.
REQ-024 Accepted issue sets busy[issue_addr] next edge; re-issue of an already busy register leaves count unchanged.
REQ-025 we=1 clears busy[waddr] next edge.
REQ-026 Same-edge issue and write to the same register: issue wins, bit stays set.
REQ-027 flush=1 clears all busy bits next edge, overriding issue and write clears; register contents still written.
REQ-028 rd_hazard[i] = busy[raddr_i] and not (BYPASS=1, we=1, waddr=raddr_i); always 0 for PC_REG.
REQ-029 pend_count SHALL be registered and always equal popcount(busy).

Reset
REQ-030 reset=0 SHALL immediately clear all registers, busy and pend_count to 0; issue_ready=1, rd_hazard=0.
REQ-031 Reset mid-operation discards pending issues and writes; first update occurs on the first edge after release.

Structure
REQ-032 Default parameter values and PC_REG encoding SHALL live in shared package regfile_pkg.
REQ-033 One sub-module regfile_read_port (source mux, bypass, hazard) SHALL be instantiated NRP times by generate.
REQ-034 Storage and scoreboard SHALL be written on rising clk only; no negative-edge logic.

Verification
REQ-035 Reset, write r3=0xDEADBEEF, next cycle raddr0=3 -> rdata0=0xDEADBEEF; r3 before write reads 0.
REQ-036 we=1 waddr=5 wdata=0x1234 with raddr1=5 same cycle -> rdata1=0x1234 (BYPASS=1), stored value with BYPASS=0.
REQ-037 Issue r2, r4, r6, r7 -> pend_count=4, issue_ready=0; fifth issue ignored; write r4 -> pend_count=3, ready=1.
REQ-038 busy[2]=1, raddr0=2 -> rd_hazard[0]=1; same cycle we to r2 -> rd_hazard[0]=0, next cycle busy[2]=0.
REQ-039 Issue and write r9 same edge -> busy[9]=1; then flush with issue r1 -> busy all 0, pend_count=0.
REQ-040 Write PC_REG=0x55, pc_in=0xAA, raddr0=PC_REG -> rdata0=0xAA; reset asserted mid-sequence -> all outputs at reset values asynchronously.
